// File: rtl/ac97_link.sv
// ac97_link: bit-serial AC'97 link engine on the codec bit clock. It generates SYNC and
// one 256-bit frame in each direction, and exchanges 8-bit PCM samples once per frame.
// Define AC97_LINK_CMD_EN to generate the codec register-write slots 1/2.

module ac97_link (
  input  logic        clock,
  input  logic        reset,
  input  logic        sdata_in,
  output logic        sdata_out,
  output logic        sync,
  output logic        ready,
  output logic [7:0]  from_ac97_data,
  input  logic [7:0]  to_ac97_data,
  input  logic        command_valid,
  input  logic [6:0]  command_address,
  input  logic [15:0] command_data,
  output logic        codec_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [7:0] LAST_BIT  = 8'd255;
  localparam logic [7:0] TAG_END   = 8'd16;
  localparam logic [7:0] PCM_L_MSB = 8'd56;
  localparam logic [7:0] PCM_L_LSB = 8'd63;
  localparam logic [7:0] PCM_R_MSB = 8'd76;
  localparam logic [7:0] PCM_R_LSB = 8'd83;

  logic [0:0] state;
  logic       running;
  logic       frame_end;
  logic [7:0] bit_count;
  logic [7:0] next_count;
  logic       next_bit;
  logic [7:0] tx_sample;
  logic [7:0] rx_shift;
  logic       rx_tag;

`ifdef AC97_LINK_CMD_EN
  localparam logic [7:0] ADDR_MSB = 8'd17;
  localparam logic [7:0] ADDR_LSB = 8'd23;
  localparam logic [7:0] DATA_MSB = 8'd36;
  localparam logic [7:0] DATA_LSB = 8'd51;

  logic        cmd_valid_q;
  logic [6:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;
`endif

  assign running   = (state == ST_RUN);
  assign frame_end = running && (bit_count == LAST_BIT);

  // The IDLE cycle after reset holds the counter at 0 so the first frame starts cleanly.
  assign next_count = running ? bit_count + 8'd1 : 8'd0;

  // SYNC and SDATA_OUT are registered: each edge computes the bit shown during next_count.
  always_comb begin
    next_bit = 1'b0;
    if (next_count == 8'd0 || next_count == 8'd3 || next_count == 8'd4) begin
      next_bit = 1'b1;
    end else if (next_count >= PCM_L_MSB && next_count <= PCM_L_LSB) begin
      next_bit = tx_sample[3'(PCM_L_LSB - next_count)];
    end else if (next_count >= PCM_R_MSB && next_count <= PCM_R_LSB) begin
      next_bit = tx_sample[3'(PCM_R_LSB - next_count)];
`ifdef AC97_LINK_CMD_EN
    end else if (next_count == 8'd1 || next_count == 8'd2) begin
      next_bit = cmd_valid_q;
    end else if (next_count >= ADDR_MSB && next_count <= ADDR_LSB) begin
      next_bit = cmd_addr_q[3'(ADDR_LSB - next_count)];
    end else if (next_count >= DATA_MSB && next_count <= DATA_LSB) begin
      next_bit = cmd_data_q[4'(DATA_LSB - next_count)];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      bit_count      <= 8'd0;
      sync           <= 1'b0;
      sdata_out      <= 1'b0;
      ready          <= 1'b0;
      from_ac97_data <= 8'd0;
      codec_ready    <= 1'b0;
      tx_sample      <= 8'd0;
      rx_shift       <= 8'd0;
      rx_tag         <= 1'b0;
    end else begin
      state     <= ST_RUN;
      bit_count <= next_count;
      sync      <= (next_count < TAG_END);
      sdata_out <= next_bit;
      ready     <= frame_end;

      if (running && bit_count == 8'd0) begin
        rx_tag <= sdata_in;
      end
      if (running && bit_count >= PCM_L_MSB && bit_count <= PCM_L_LSB) begin
        rx_shift <= {rx_shift[6:0], sdata_in};
      end

      // Frame boundary: publish the capture and freeze the playback sample for the next frame.
      if (frame_end) begin
        from_ac97_data <= rx_shift;
        codec_ready    <= rx_tag;
        tx_sample      <= to_ac97_data;
      end
    end
  end

`ifdef AC97_LINK_CMD_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 7'd0;
      cmd_data_q  <= 16'd0;
    end else if (frame_end) begin
      cmd_valid_q <= command_valid;
      cmd_addr_q  <= command_address;
      cmd_data_q  <= command_data;
    end
  end
`else
  logic unused_cmd;
  assign unused_cmd = ^{command_valid, command_address, command_data};
`endif

endmodule

// File: tb/tb_ac97_link.sv
// tb_ac97_link: directed bench for ac97_link with a frame-level reference model
// that is compared against the DUT outputs on every cycle.

module tb_ac97_link;

`ifdef AC97_LINK_CMD_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sdata_in = 1'b0;
  logic        sdata_out;
  logic        sync;
  logic        ready;
  logic [7:0]  from_ac97_data;
  logic [7:0]  to_ac97_data = 8'h00;
  logic        command_valid = 1'b0;
  logic [6:0]  command_address = 7'h00;
  logic [15:0] command_data = 16'h0000;
  logic        codec_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Codec stimulus: tag bit 0 and the slot-3 byte; all other input bits are driven to 1
  // (except the 12 zero bits trailing the sample) to show they are ignored.
  logic [7:0] codec_byte = 8'h5A;
  logic       codec_tag  = 1'b1;

  // Reference model state: position in frame (-1 = not running) and frame being sent.
  int           m_pos = -1;
  logic [255:0] m_frame = '0;
  logic [7:0]   m_rx = 8'h00;
  logic         m_tag = 1'b0;
  logic [7:0]   m_from = 8'h00;
  logic         m_cr = 1'b0;
  logic         m_ready = 1'b0;

  ac97_link dut (
    .clock           (clock),
    .reset           (reset),
    .sdata_in        (sdata_in),
    .sdata_out       (sdata_out),
    .sync            (sync),
    .ready           (ready),
    .from_ac97_data  (from_ac97_data),
    .to_ac97_data    (to_ac97_data),
    .command_valid   (command_valid),
    .command_address (command_address),
    .command_data    (command_data),
    .codec_ready     (codec_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] build_frame(input logic [7:0] s, input logic cv,
                                               input logic [6:0] a, input logic [15:0] d);
    logic        v;
    logic [15:0] tag;
    logic [19:0] s1, s2, pcm;
    v   = cv & CMD_EN;
    tag = {1'b1, v, v, 1'b1, 1'b1, 11'b0};
    s1  = CMD_EN ? {1'b0, a, 12'b0} : 20'b0;
    s2  = CMD_EN ? {d, 4'b0} : 20'b0;
    pcm = {s, 12'b0};
    return {tag, s1, s2, pcm, pcm, 160'b0};
  endfunction

  // Model: advances one frame position per edge and swaps frames at the boundary.
  always @(posedge clock) begin
    if (reset) begin
      m_pos = -1; m_frame = '0; m_rx = 8'h00; m_tag = 1'b0;
      m_from = 8'h00; m_cr = 1'b0; m_ready = 1'b0;
    end else begin
      m_ready = 1'b0;
      if (m_pos == 0) m_tag = sdata_in;
      if (m_pos >= 56 && m_pos <= 63) m_rx[63 - m_pos] = sdata_in;
      if (m_pos == 255) begin
        m_from = m_rx; m_cr = m_tag; m_ready = 1'b1; m_pos = 0;
        m_frame = build_frame(to_ac97_data, command_valid, command_address, command_data);
      end else if (m_pos < 0) begin
        m_pos = 0;
        m_frame = build_frame(8'h00, 1'b0, 7'h00, 16'h0000);
      end else begin
        m_pos++;
      end
    end
  end

  // Compare every cycle on the falling edge, then drive the codec bit for this cycle.
  always @(negedge clock) begin
    check("sync", {31'b0, sync}, {31'b0, m_pos >= 0 && m_pos < 16});
    check("sdata_out", {31'b0, sdata_out}, {31'b0, m_pos >= 0 && m_frame[255 - m_pos]});
    check("ready", {31'b0, ready}, {31'b0, m_ready});
    check("from_ac97_data", {24'b0, from_ac97_data}, {24'b0, m_from});
    check("codec_ready", {31'b0, codec_ready}, {31'b0, m_cr});
    if (m_pos == 0)                     sdata_in = codec_tag;
    else if (m_pos >= 56 && m_pos <= 63) sdata_in = codec_byte[63 - m_pos];
    else if (m_pos >= 64 && m_pos <= 75) sdata_in = 1'b0;
    else                                 sdata_in = 1'b1;
  end

  // Records one outgoing frame starting at the bit-0 cycle; applies new inputs at bit chg_at.
  task automatic grab_frame(input int chg_at, input logic [7:0] n_to, input logic n_cv,
                            input logic [6:0] n_addr, input logic [15:0] n_data,
                            input logic [7:0] n_byte, input logic n_tag,
                            output logic [255:0] f);
    for (int i = 0; i < 256; i++) begin
      f[255 - i] = sdata_out;
      if (i == chg_at) begin
        to_ac97_data = n_to; command_valid = n_cv; command_address = n_addr;
        command_data = n_data; codec_byte = n_byte; codec_tag = n_tag;
      end
      @(negedge clock);
    end
  endtask

  task automatic check_frame(input string tag_name, input logic [255:0] f,
                             input logic [15:0] tag, input logic [19:0] s1,
                             input logic [19:0] s2, input logic [19:0] pcm);
    check({tag_name, " tag"},   {16'b0, f[255:240]}, {16'b0, tag});
    check({tag_name, " slot1"}, {12'b0, f[239:220]}, {12'b0, s1});
    check({tag_name, " slot2"}, {12'b0, f[219:200]}, {12'b0, s2});
    check({tag_name, " slot3"}, {12'b0, f[199:180]}, {12'b0, pcm});
    check({tag_name, " slot4"}, {12'b0, f[179:160]}, {12'b0, pcm});
    check({tag_name, " tail"},  {31'b0, |f[159:0]}, 32'd0);
  endtask

  initial begin
    logic [255:0] f;
    int cnt;
    to_ac97_data = 8'h11;
    repeat (3) @(negedge clock);
    check("reset sync", {31'b0, sync}, 32'd0);
    check("reset sdata_out", {31'b0, sdata_out}, 32'd0);
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset from", {24'b0, from_ac97_data}, 32'd0);
    check("reset codec_ready", {31'b0, codec_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("first sync", {31'b0, sync}, 32'd1);
    check("first sdata_out", {31'b0, sdata_out}, 32'd1);

    cnt = 0;
    while (!ready && cnt < 400) begin @(negedge clock); cnt++; end
    check("first ready latency", cnt, 32'd256);
    check("R1 from", {24'b0, from_ac97_data}, 32'h5A);
    check("R1 codec_ready", {31'b0, codec_ready}, 32'd1);

    grab_frame(100, 8'h11, 1'b1, 7'h02, 16'h0808, 8'hC3, 1'b0, f);
    check("R2 ready", {31'b0, ready}, 32'd1);
    check("R2 from", {24'b0, from_ac97_data}, 32'h5A);
    check_frame("F2", f, 16'h9800, 20'h0, 20'h0, 20'h11000);

    grab_frame(60, 8'h22, 1'b0, 7'h00, 16'h0000, 8'hC3, 1'b0, f);
    check("R3 ready", {31'b0, ready}, 32'd1);
    check("R3 from", {24'b0, from_ac97_data}, 32'hC3);
    check("R3 codec_ready", {31'b0, codec_ready}, 32'd0);
    check_frame("F3", f, CMD_EN ? 16'hF800 : 16'h9800, CMD_EN ? 20'h02000 : 20'h0,
                CMD_EN ? 20'h08080 : 20'h0, 20'h11000);

    grab_frame(999, 8'h22, 1'b0, 7'h00, 16'h0000, 8'hC3, 1'b0, f);
    check("R4 ready", {31'b0, ready}, 32'd1);
    check_frame("F4", f, 16'h9800, 20'h0, 20'h0, 20'h22000);

    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset sync", {31'b0, sync}, 32'd0);
    check("midreset from", {24'b0, from_ac97_data}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("restart sync", {31'b0, sync}, 32'd1);
    check("restart sdata_out", {31'b0, sdata_out}, 32'd1);
    cnt = 0;
    while (!ready && cnt < 400) begin @(negedge clock); cnt++; end
    check("restart ready latency", cnt, 32'd256);
    check("restart from", {24'b0, from_ac97_data}, 32'hC3);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ac97_link.md
# ac97_link

Bit-serial AC'97 link engine: the codec-facing end of the `ready` / `from_ac97_data` / `to_ac97_data` sample interface consumed by the recorder. It runs on the codec bit clock, generates SYNC, serializes one 256-bit output frame and deserializes one 256-bit input frame per 48 kHz period. Once per frame it presents the captured 8-bit left-channel sample with a one-cycle `ready` strobe and latches the recorder's 8-bit playback sample for the next frame. It sits between the AC'97 pins and the recorder, with command slots for codec register writes.

## Interface
- No parameters. Frame length 256 bits, slot layout and 8-bit sample width are fixed.
- `clock` in 1 — AC'97 bit clock (12.288 MHz); the only clock; all logic on rising edge.
- `reset` in 1 — synchronous, active-high.
- `sdata_in` in 1 — serial data from codec.
- `sdata_out` out 1 — serial data to codec.
- `sync` out 1 — AC'97 SYNC.
- `ready` out 1 — one-cycle strobe: new `from_ac97_data` valid, `to_ac97_data` just latched.
- `from_ac97_data` out 8 — captured left sample, two's complement, top 8 bits of slot 3.
- `to_ac97_data` in 8 — playback sample, two's complement.
- `command_valid` in 1 — level; send a register write in the next frame.
- `command_address` in 7 — codec register address.
- `command_data` in 16 — codec register data.
- `codec_ready` out 1 — tag bit 15 of the last complete input frame.

## Operation
- 8-bit frame counter `bit_count`, 0..255, increments every cycle and wraps 255→0. During the cycle `bit_count == k`, `sync` and `sdata_out` present frame bit k. `sdata_in` is sampled at the rising edge that ends that cycle as input bit k.
- `sync` = 1 for bits 0..15 (tag slot), 0 for bits 16..255.
- Output frame, MSB first:
  - Tag, bits 0..15: bit0 = valid frame (1), bit1 = slot1 valid (latched command_valid), bit2 = slot2 valid (same), bit3 = slot3 valid (1), bit4 = slot4 valid (1), rest 0.
  - Slot 1, bits 16..35: write bit 0, then `command_address[6:0]`, then 12 zeros.
  - Slot 2, bits 36..55: `command_data[15:0]`, then 4 zeros.
  - Slot 3, bits 56..75: latched sample[7:0], then 12 zeros (MSB-aligned 20-bit PCM).
  - Slot 4, bits 76..95: identical to slot 3 (mono to both channels).
  - Bits 96..255: 0.
- Input frame: input bit 0 → `codec_ready` candidate; input bits 56..63 → slot-3 sample MSB..LSB, shifted into a capture register. All other input bits are ignored.
- Frame boundary, at the edge ending `bit_count == 255`:
  - `from_ac97_data` ← captured byte.
  - `codec_ready` ← captured tag bit.
  - `ready` ← 1.
  - `to_ac97_data`, `command_valid`, `command_address` and `command_data` are latched into the transmit holding registers. They are held constant for the whole following frame.
- `ready` returns to 0 at the next edge, so it is high exactly during `bit_count == 0`.
- Input changes mid-frame have no effect on the frame in progress.

## Timing
- Reset values: `bit_count` 0, `sync` 0, `sdata_out` 0, `ready` 0, `from_ac97_data` 0, `codec_ready` 0, holding registers 0.
- First cycle after `reset` falls: `bit_count` = 0, `sync` = 1, `sdata_out` = tag bit 0 = 1. No `ready` is issued for this first frame boundary; the first `ready` comes after a complete frame, 256 cycles after reset release.
- `ready` period: exactly 256 cycles; pulse width: exactly 1 cycle.
- Capture latency: input bit 63 is sampled, then `from_ac97_data` updates 192 edges later, with `ready`.
- Playback latency: a `to_ac97_data` value present at the `ready`-generating edge appears on `sdata_out` during `bit_count` 56..63 of the frame that starts immediately.
- A recorder that updates `to_ac97_data` in response to `ready` is therefore transmitted one frame later.
- Reset mid-frame: the frame is abandoned, all outputs go to reset values the next cycle, and no `ready` is produced for the partial frame.
- `command_valid` deasserted before the latch edge: no command is sent; a held level resends every frame.

## Configuration
- `AC97_LINK_CMD_EN` defined: command slots 1/2 and tag bits 1/2 are generated as above.
- `AC97_LINK_CMD_EN` undefined: the command ports are present but ignored, tag bits 1/2 and slots 1/2 are always 0, and no command holding registers are synthesized.

## Test plan
- Reset held 3 cycles, then released:
  - all outputs 0 during reset;
  - `sync` high for exactly 16 cycles then low for 240, repeating;
  - `ready` first high 256 cycles after release, then every 256 cycles, width 1.
- Codec model drives 0x5A (followed by 12 zero bits) in slot 3 and 1 at tag bit 0 → at the next `ready`, `from_ac97_data` = 0x5A and `codec_ready` = 1.
- `to_ac97_data` = 0x11 held at the `ready` edge → `sdata_out` bits 56..75 and bits 76..95 each equal 0x11000; tag bits 0..4 = 1,0,0,1,1 (command idle).
- `command_valid` = 1, address 0x02, data 0x0808 → next frame tag bits 1/2 = 1, slot 1 = 0x02000, slot 2 = 0x08080. With `AC97_LINK_CMD_EN` undefined, the same stimulus gives tag bits 1/2 = 0 and slots 1/2 all zero.
- `to_ac97_data` changed 0x11→0x22 at `bit_count` 60 → the current frame still sends 0x11; the next frame sends 0x22.
- `reset` pulsed at `bit_count` 100 → no `ready` for that frame; `sync` restarts at 16 cycles high the cycle after release; `from_ac97_data` reads 0 until the next full frame.
